imm_extend_stage: RTL and testbench

Decode-to-execute pipeline stage that generates the 32-bit immediate operand from a 16-bit instruction immediate.
- Extension modes: sign, zero, upper (LUI) and branch-offset.
- Registered output with a valid/ready handshake and a one-entry skid buffer, so ID/EX stalls never drop or duplicate an immediate.
- Sits between the decoder and the EX operand mux. Also supports pipeline flush and keeps a transfer counter for debug.

---
 rtl/imm_extend_stage.sv | 97 +++++++++
 tb/tb_imm_extend_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/imm_extend_stage.sv
// ID/EX immediate generator: extends a 16-bit immediate to a 32-bit operand and
// registers it behind a valid/ready handshake with a one-entry skid buffer.
module imm_extend_stage #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  localparam logic [1:0] M_SEXT = 2'b00, M_ZEXT = 2'b01, M_UPPER = 2'b10, M_BR = 2'b11;

  ent_t             w_in_ent, r_out, r_skid;
  logic [DATA_W-1:0] w_ext;
  logic             r_out_valid, r_skid_valid, r_in_ready;
  logic [CNT_W-1:0] r_xfer_count;
  logic             w_accept, w_fire, w_out_load, w_skid_valid_nxt;

  always_comb begin
    w_ext = '0;
    case (in_mode)
      M_SEXT:  w_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
      M_ZEXT:  w_ext = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      M_UPPER: w_ext = {in_imm, {(DATA_W-IMM_W){1'b0}}};
      M_BR:    w_ext = {{(DATA_W-IMM_W-2){in_imm[IMM_W-1]}}, in_imm, 2'b00};
      default: w_ext = '0;
    endcase
  end

  assign w_in_ent   = '{data: w_ext, tag: in_tag};
  assign w_accept   = in_valid & r_in_ready;
  assign w_fire     = r_out_valid & out_ready;
  assign w_out_load = !r_out_valid | out_ready;

  // Skid fills only when the output is stalled; it empties whenever the output reloads.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (flush)                        w_skid_valid_nxt = 1'b0;
    else if (w_out_load)              w_skid_valid_nxt = 1'b0;
    else if (w_accept)                w_skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_xfer_count <= '0;
    end else begin
      r_xfer_count <= r_xfer_count + CNT_W'(w_fire);
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_out_load) begin
        if (r_skid_valid) begin
          r_out       <= r_skid;
          r_out_valid <= 1'b1;
        end else if (w_accept) begin
          r_out       <= w_in_ent;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid <= w_in_ent;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out.data;
  assign out_tag    = r_out.tag;
  assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: modes, backpressure, streaming, flush,
// async reset mid-stall and counter wrap (CNT_W=4).
module tb_imm_extend_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;
  logic [3:0]  xfer_count;

  int errors = 0;
  int checks = 0;

  imm_extend_stage #(.IMM_W(16), .DATA_W(32), .TAG_W(5), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .xfer_count(xfer_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 2'b00, 5'd0);
    flush = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 5'd0);
    reset = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_out_tag",   {27'd0, out_tag},   32'd0);
    chk("rst_count",     {28'd0, xfer_count}, 32'd0);
    tick();
    reset = 1'b0;

    // Extension modes
    out_ready = 1'b1;
    drive(1'b1, 16'h8000, 2'b00, 5'd1); tick();
    chk("mode00", out_data, 32'hFFFF8000);
    drive(1'b1, 16'h8000, 2'b01, 5'd2); tick();
    chk("mode01", out_data, 32'h00008000);
    drive(1'b1, 16'h8000, 2'b10, 5'd3); tick();
    chk("mode10", out_data, 32'h80000000);
    drive(1'b1, 16'h8000, 2'b11, 5'd4); tick();
    chk("mode11_8000", out_data, 32'hFFFE0000);
    drive(1'b1, 16'hFFFF, 2'b11, 5'd5); tick();
    chk("mode11_ffff", out_data, 32'hFFFFFFFC);
    chk("mode11_tag", {27'd0, out_tag}, 32'd5);
    drive(1'b0, 16'h0, 2'b00, 5'd0); tick();
    chk("modes_count", {28'd0, xfer_count}, 32'd5);
    chk("modes_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure with skid
    do_reset();
    drive(1'b1, 16'h0001, 2'b00, 5'd3); tick();
    chk("bp_A_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 16'h0002, 2'b00, 5'd4); tick();
    chk("bp_hold_A", out_data, 32'h00000001);
    chk("bp_hold_tag", {27'd0, out_tag}, 32'd3);
    chk("bp_in_ready_lo", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h0005, 2'b00, 5'd7); tick();
    chk("bp_C_blocked", out_data, 32'h00000001);
    chk("bp_still_lo", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; tick();
    chk("bp_B_out", out_data, 32'h00000002);
    chk("bp_B_tag", {27'd0, out_tag}, 32'd4);
    chk("bp_in_ready_hi", {31'd0, in_ready}, 32'd1);
    chk("bp_count1", {28'd0, xfer_count}, 32'd1);
    drive(1'b0, 16'h0, 2'b00, 5'd0); tick();
    chk("bp_no_C", {31'd0, out_valid}, 32'd0);
    chk("bp_count2", {28'd0, xfer_count}, 32'd2);

    // Streaming
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 2'b01, 5'(i)); tick();
      chk($sformatf("stream_data%0d", i), out_data, 32'h00000100 + i);
      chk($sformatf("stream_rdy%0d", i), {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 16'h0, 2'b00, 5'd0); tick();
    chk("stream_count", {28'd0, xfer_count}, 32'd8);

    // Flush with A on output and B in skid
    do_reset();
    drive(1'b1, 16'h0001, 2'b00, 5'd3); tick();
    drive(1'b1, 16'h0002, 2'b00, 5'd4); tick();
    flush = 1'b1;
    drive(1'b1, 16'h0009, 2'b00, 5'd9); tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 5'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_count", {28'd0, xfer_count}, 32'd0);
    out_ready = 1'b1; tick();
    chk("flush_no_9", {31'd0, out_valid}, 32'd0);
    chk("flush_count2", {28'd0, xfer_count}, 32'd0);

    // Async reset mid-stall
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 16'h0033, 2'b00, 5'd1); tick();
    drive(1'b0, 16'h0, 2'b00, 5'd0); tick();
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 2'b00, 5'd3); tick();
    drive(1'b1, 16'h0002, 2'b00, 5'd4); tick();
    drive(1'b0, 16'h0, 2'b00, 5'd0);
    chk("ar_pre_count", {28'd0, xfer_count}, 32'd1);
    chk("ar_pre_ready", {31'd0, in_ready}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_count", {28'd0, xfer_count}, 32'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'h7FFF, 2'b00, 5'd2); tick();
    chk("ar_fresh", out_data, 32'h00007FFF);
    drive(1'b0, 16'h0, 2'b00, 5'd0); tick();
    chk("ar_drained", {31'd0, out_valid}, 32'd0);

    // Counter wrap with CNT_W=4
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 16'(i), 2'b01, 5'd0); tick();
    end
    drive(1'b0, 16'h0, 2'b00, 5'd0); tick();
    chk("wrap_count", {28'd0, xfer_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
